quire_to_posit_4_0: RTL and testbench

//  Consumes the 19-bit two's-complement fixed-point quire from the posit<4,0> accumulator and rounds it to a 4-bit posit<4,0> (RNE on encoding).

---
 rtl/quire_to_posit_4_0.sv | 124 ++++++++++++
 tb/tb_quire_to_posit_4_0.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/quire_to_posit_4_0.sv
// Rounds the 19-bit fixed-point quire (LSB = 1/16) of the posit<4,0> accumulator to a
// 4-bit posit<4,0>, round-to-nearest-even on encoding, over a 2-stage rts/rtr pipeline.
module quire_to_posit_4_0 #(
    parameter bit EOW_ONLY   = 1'b1,
    parameter int QUIRE_SIZE = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  rtr_o,
    input  logic                  rts_i,
    input  logic                  sow_i,
    input  logic                  eow_i,
    input  logic [QUIRE_SIZE-1:0] data_i,
    input  logic                  sign_i,
    input  logic                  zero_i,
    input  logic                  NaR_i,
    input  logic                  rtr_i,
    output logic                  rts_o,
    output logic                  sow_o,
    output logic                  eow_o,
    output logic [3:0]            posit_o,
    output logic                  NaR_o,
    output logic                  zero_o
);

    generate
        if (QUIRE_SIZE != 19) begin : g_bad_quire_size
            $error("quire_to_posit_4_0: QUIRE_SIZE must be 19");
        end
    endgenerate

    logic                  process_en;
    logic                  accept;
    logic                  keep;
    logic                  data_zero;
    logic [QUIRE_SIZE-1:0] abs_val;

    logic                  s1_valid;
    logic [QUIRE_SIZE-1:0] s1_mag;
    logic                  s1_neg;
    logic                  s1_nar;
    logic                  s1_sow;
    logic                  s1_eow;

    logic                  mag_small;
    logic [5:0]            mag_lo;
    logic [2:0]            mag_code;
    logic [3:0]            result;

    assign process_en = rtr_i | ~rts_o;
    assign accept     = rts_i & rtr_o & process_en;
    assign keep       = accept & (eow_i | ~EOW_ONLY);
    assign data_zero  = (data_i == '0);
    // -2^18 negates to itself, which read as unsigned is exactly 2^18
    assign abs_val    = data_i[QUIRE_SIZE-1] ? -data_i : data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtr_o    <= 1'b0;
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_neg   <= 1'b0;
            s1_nar   <= 1'b0;
            s1_sow   <= 1'b0;
            s1_eow   <= 1'b0;
        end else begin
            rtr_o <= process_en;
            if (process_en) begin
                s1_valid <= keep;
                // The sign/zero hints can only refine a zero quire, which maps to 0000 anyway
                s1_mag   <= (zero_i & data_zero) ? '0 : abs_val;
                s1_neg   <= data_i[QUIRE_SIZE-1] | (sign_i & data_zero);
                s1_nar   <= NaR_i;
                s1_sow   <= sow_i;
                s1_eow   <= eow_i;
            end
        end
    end

    assign mag_small = (s1_mag[QUIRE_SIZE-1:6] == '0);
    assign mag_lo    = s1_mag[5:0];

    // Thresholds in 1/16 units; ties (6,10,14,20,28,48) land on the even code
    always_comb begin
        mag_code = 3'd7;
        if (mag_small) begin
            if (mag_lo == 6'd0)       mag_code = 3'd0;
            else if (mag_lo <= 6'd5)  mag_code = 3'd1;
            else if (mag_lo <= 6'd10) mag_code = 3'd2;
            else if (mag_lo <= 6'd13) mag_code = 3'd3;
            else if (mag_lo <= 6'd20) mag_code = 3'd4;
            else if (mag_lo <= 6'd27) mag_code = 3'd5;
            else if (mag_lo <= 6'd48) mag_code = 3'd6;
            else                      mag_code = 3'd7;
        end
    end

    always_comb begin
        result = {1'b0, mag_code};
        if (s1_nar)
            result = 4'b1000;
        else if (s1_neg)
            result = 4'd0 - {1'b0, mag_code};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_o   <= 1'b0;
            posit_o <= 4'd0;
            NaR_o   <= 1'b0;
            zero_o  <= 1'b0;
            sow_o   <= 1'b0;
            eow_o   <= 1'b0;
        end else if (process_en) begin
            rts_o   <= s1_valid;
            posit_o <= s1_valid ? result : 4'd0;
            NaR_o   <= s1_valid & (result == 4'b1000);
            zero_o  <= s1_valid & (result == 4'd0);
            sow_o   <= s1_valid & s1_sow;
            eow_o   <= s1_valid & s1_eow;
        end
    end

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Bench for quire_to_posit_4_0: nearest-posit reference model with a beat scoreboard,
// directed rounding cases, window filtering, stalls, random traffic and a mid-stream reset.
module tb_quire_to_posit_4_0;

    logic        clk;
    logic        rst_n;
    logic        rtr_o;
    logic        rts_i;
    logic        sow_i;
    logic        eow_i;
    logic [18:0] data_i;
    logic        sign_i;
    logic        zero_i;
    logic        NaR_i;
    logic        rtr_i;
    logic        rts_o;
    logic        sow_o;
    logic        eow_o;
    logic [3:0]  posit_o;
    logic        NaR_o;
    logic        zero_o;

    quire_to_posit_4_0 dut (
        .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o), .rts_i(rts_i), .sow_i(sow_i),
        .eow_i(eow_i), .data_i(data_i), .sign_i(sign_i), .zero_i(zero_i),
        .NaR_i(NaR_i), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o),
        .posit_o(posit_o), .NaR_o(NaR_o), .zero_o(zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] posit;
        logic       sow;
        logic       eow;
        int         acc_cyc;
    } beat_t;

    beat_t q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    out_pulses = 0;
    bit    strict_lat = 1'b0;
    logic  rtr_exp = 1'b0;

    // Nearest posit<4,0> value in 1/16 units; ties pick the even encoding
    function automatic logic [3:0] ref_posit(input logic [18:0] qv, input logic nar);
        int vals [0:6];
        int v, m, k, p;
        vals = '{4, 8, 12, 16, 24, 32, 64};
        if (nar) return 4'b1000;
        v = int'($signed(qv));
        m = (v < 0) ? -v : v;
        if (m == 0) return 4'b0000;
        if (m >= 64) p = 7;
        else if (m <= 4) p = 1;
        else begin
            k = 0;
            while (vals[k+1] <= m) k++;
            if (2*m < vals[k] + vals[k+1]) p = k + 1;
            else if (2*m > vals[k] + vals[k+1]) p = k + 2;
            else p = ((k + 1) % 2 == 0) ? k + 1 : k + 2;
        end
        return (v < 0) ? 4'((16 - p) % 16) : 4'(p);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit v, input logic [18:0] d, input bit s, input bit e,
                         input bit nar, input bit rr, input bit zh);
        bit xfer, acc;
        @(negedge clk);
        cyc++;
        check("rtr_o", 32'(rtr_o), 32'(rtr_exp));
        if (rts_o) begin
            if (q.size() == 0) begin
                check("spurious_rts_o", 32'(rts_o), 32'd0);
            end else begin
                check("posit_o", 32'(posit_o), 32'(q[0].posit));
                check("NaR_o", 32'(NaR_o), 32'(q[0].posit == 4'b1000));
                check("zero_o", 32'(zero_o), 32'(q[0].posit == 4'b0000));
                check("sow_o", 32'(sow_o), 32'(q[0].sow));
                check("eow_o", 32'(eow_o), 32'(q[0].eow));
                if (strict_lat) check("latency", 32'(cyc - q[0].acc_cyc), 32'd2);
            end
        end else if (strict_lat && q.size() > 0 && (cyc - q[0].acc_cyc) >= 2) begin
            check("rts_o_late", 32'(rts_o), 32'd1);
        end
        rts_i  = v;
        data_i = d;
        sign_i = d[18];
        zero_i = zh | (d == 19'd0);
        sow_i  = s;
        eow_i  = e;
        NaR_i  = nar;
        rtr_i  = rr;
        xfer = rts_o & rr;
        acc  = v & rtr_o & (rr | ~rts_o);
        if (xfer && q.size() > 0) begin
            void'(q.pop_front());
            out_pulses++;
        end
        if (acc && e) q.push_back('{ref_posit(d, nar), s, e, cyc});
        rtr_exp = rr | ~rts_o;
    endtask

    task automatic idle_inputs();
        rts_i = 0; sow_i = 0; eow_i = 0; data_i = '0; sign_i = 0;
        zero_i = 0; NaR_i = 0; rtr_i = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rts_o"}, 32'(rts_o), 32'd0);
        check({tag, "_posit_o"}, 32'(posit_o), 32'd0);
        check({tag, "_rtr_o"}, 32'(rtr_o), 32'd0);
        check({tag, "_flags"}, 32'({NaR_o, zero_o, sow_o, eow_o}), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        idle_inputs();
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rtr_exp = 1'b1;
    endtask

    function automatic logic [18:0] rand_quire();
        int x;
        case ($urandom_range(0, 3))
            0: begin x = int'($urandom_range(0, 140)) - 70; return 19'(x); end
            1: return 19'($urandom);
            2: case ($urandom_range(0, 4))
                   0: return 19'h40000;
                   1: return 19'h3FFFF;
                   2: return 19'h00000;
                   3: return 19'h00001;
                   default: return 19'h7FFFF;
               endcase
            default: begin x = int'($urandom_range(0, 32)) - 16; return 19'(x); end
        endcase
    endfunction

    typedef struct {
        logic [18:0] d;
        bit          nar;
        bit          zh;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs[$];
    int   pulses0;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        rtr_exp = 1'b1;

        vecs = '{
            '{19'd16,    0, 0, 4'b0100},
            '{19'h7FFE8, 0, 0, 4'b1011},
            '{19'd48,    0, 0, 4'b0110},
            '{19'd1,     0, 0, 4'b0001},
            '{19'h40000, 0, 0, 4'b1001},
            '{19'd0,     0, 0, 4'b0000},
            '{19'd16,    1, 0, 4'b1000},
            '{19'd10,    0, 0, 4'b0010},
            '{19'd6,     0, 0, 4'b0010},
            '{19'd14,    0, 0, 4'b0100},
            '{19'd20,    0, 0, 4'b0100},
            '{19'd28,    0, 0, 4'b0110},
            '{19'd49,    0, 0, 4'b0111},
            '{19'd5,     0, 0, 4'b0001},
            '{19'd16,    0, 1, 4'b0100},
            '{19'h7FFFF, 0, 0, 4'b1111}
        };
        foreach (vecs[i]) check("model_pin", 32'(ref_posit(vecs[i].d, vecs[i].nar)), 32'(vecs[i].exp));

        // Directed values streamed back to back with downstream always ready
        strict_lat = 1'b1;
        foreach (vecs[i]) cycle(1, vecs[i].d, 0, 1, vecs[i].nar, 1, vecs[i].zh);
        repeat (4) cycle(0, '0, 0, 0, 0, 1, 0);
        check("directed_drain", 32'(q.size()), 32'd0);

        // 8-beat window, eow only on the last beat
        pulses0 = out_pulses;
        for (int i = 0; i < 8; i++) cycle(1, rand_quire(), i == 0, i == 7, 0, 1, 0);
        repeat (4) cycle(0, '0, 0, 0, 0, 1, 0);
        check("window_pulses", 32'(out_pulses - pulses0), 32'd1);

        // 1-beat window carries both markers
        pulses0 = out_pulses;
        cycle(1, 19'd24, 1, 1, 0, 1, 0);
        repeat (4) cycle(0, '0, 0, 0, 0, 1, 0);
        check("single_window_pulses", 32'(out_pulses - pulses0), 32'd1);

        // Downstream stall for 5 clk while upstream keeps offering
        strict_lat = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, rand_quire(), 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, rand_quire(), 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, rand_quire(), 0, 1, 0, 1, 0);
        repeat (4) cycle(0, '0, 0, 0, 0, 1, 0);
        check("stall_drain", 32'(q.size()), 32'd0);

        // Random traffic with stalls and one reset mid-stream
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) pulse_reset();
            cycle($urandom_range(0, 3) != 0, rand_quire(), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) < 3, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
        end
        for (int i = 0; i < 50 && q.size() > 0; i++) cycle(0, '0, 0, 0, 0, 1, 0);
        repeat (3) cycle(0, '0, 0, 0, 0, 1, 0);
        check("final_drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
